// File: rtl/uart_rx_frontend.sv
// UART receive front end: oversampling tick divider, 2-flop rx synchronizer,
// 8N1 receive FSM with sticky framing error and one-clk done pulse.
`timescale 1ns/1ps
module uart_rx_frontend #(
    parameter int unsigned CLOCK_RATE = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       en,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam int unsigned DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;
    logic             rx_meta;
    logic             rx_sync;

    state_t           state,     state_n;
    logic [CNT_W-1:0] samp_cnt,  samp_cnt_n;
    logic [2:0]       bit_idx,   bit_idx_n;
    logic [7:0]       shift_reg, shift_reg_n;
    logic [7:0]       data_n;
    logic             err_n;
    logic             busy_n;
    logic             frame_done_c;

    assign tick_c = (div_cnt == DIV_MAX);

    // Free-running oversample tick divider
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous rx pin, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Next-state and output logic; frame work happens only on tick cycles
    always_comb begin
        state_n      = state;
        samp_cnt_n   = samp_cnt;
        bit_idx_n    = bit_idx;
        shift_reg_n  = shift_reg;
        data_n       = data_out;
        err_n        = err;
        frame_done_c = 1'b0;

        if (!en) begin
            state_n    = IDLE;
            samp_cnt_n = '0;
            bit_idx_n  = '0;
        end else if (tick_c) begin
            unique case (state)
                IDLE: begin
                    samp_cnt_n = '0;
                    bit_idx_n  = '0;
                    if (!rx_sync) begin
                        state_n = START;
                    end
                end
                START: begin
                    if (samp_cnt == HALF_MAX) begin
                        samp_cnt_n = '0;
                        if (!rx_sync) begin
                            err_n     = 1'b0;
                            bit_idx_n = '0;
                            state_n   = DATA;
                        end else begin
                            state_n   = IDLE;
                        end
                    end else begin
                        samp_cnt_n = samp_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (samp_cnt == FULL_MAX) begin
                        samp_cnt_n           = '0;
                        shift_reg_n[bit_idx] = rx_sync;
                        if (bit_idx == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end else begin
                        samp_cnt_n = samp_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (samp_cnt == FULL_MAX) begin
                        samp_cnt_n = '0;
                        if (rx_sync) begin
                            data_n       = shift_reg;
                            frame_done_c = 1'b1;
                            state_n      = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = WAIT_IDLE;
                        end
                    end else begin
                        samp_cnt_n = samp_cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n == START) || (state_n == DATA) || (state_n == STOP);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_out  <= 8'h00;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            samp_cnt  <= samp_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_reg_n;
            data_out  <= data_n;
            done      <= frame_done_c;
            busy      <= busy_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: table of 8N1 frames plus
// hand-written glitch, enable-drop and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] data_out;
    logic       done;
    logic       busy;
    logic       err;

    int         total    = 0;
    int         bad      = 0;
    int         done_cnt = 0;
    int         pushed   = 0;
    logic [7:0] sb_q[$];

    uart_rx_frontend #(
        .CLOCK_RATE(6_400_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .en      (en),
        .data_out(data_out),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d);
        sb_q.push_back(d);
        pushed++;
    endtask

    // Done monitor: pops the scoreboard and checks pulse width and data hold
    logic [7:0] prev_data = 8'h00;
    logic       done_prev = 1'b0;
    logic       rst_last  = 1'b1;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_width", 32'(done_prev), 32'(0));
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got data %0h expected no done", data_out);
            end else begin
                check("sb_data", 32'(data_out), 32'(sb_q.pop_front()));
            end
        end
        if (!rst_last && !done && data_out !== prev_data) begin
            total++;
            bad++;
            $display("FAIL data_hold: got %0h expected %0h", data_out, prev_data);
        end
        prev_data = data_out;
        done_prev = done;
        rst_last  = rst;
    end

    // Drive one 8N1 frame; optionally drop en or pulse rst at data bit cut_bit
    task automatic send_byte(input logic [7:0] d, input logic stop_v, input int stop_len,
                             input int cut_bit, input logic cut_rst, input logic chk_busy);
        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == cut_bit) begin
                if (cut_rst) begin
                    rst = 1'b1;
                    hold(1);
                    rst = 1'b0;
                    check("rst_data", 32'(data_out), 32'(8'h00));
                    check("rst_done", 32'(done), 32'(0));
                    check("rst_busy", 32'(busy), 32'(0));
                    check("rst_err", 32'(err), 32'(0));
                end else begin
                    en = 1'b0;
                    hold(1);
                    check("en_abort_busy", 32'(busy), 32'(0));
                end
                hold(BIT - 1);
            end else if (i == 4 && chk_busy) begin
                hold(BIT / 2);
                check("busy_mid", 32'(busy), 32'(1));
                hold(BIT / 2);
            end else begin
                hold(BIT);
            end
        end
        rx = stop_v;
        hold(BIT * stop_len);
        rx = 1'b1;
        if (chk_busy) check("busy_end", 32'(busy), 32'(0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        int         stop_len;
        int         gap;
        logic       pre_err;
        logic       exp_done;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int c0;
        vecs[0] = '{8'hA5, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[4] = '{8'h55, 1'b0, 2, 1, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[5] = '{8'h12, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0, 8'h12};

        rst = 1'b1;
        hold(5);
        check("reset_data", 32'(data_out), 32'(8'h00));
        check("reset_done", 32'(done), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_err", 32'(err), 32'(0));
        rst = 1'b0;
        hold(2 * BIT);

        for (int i = 0; i < 6; i++) begin
            hold(vecs[i].gap * BIT);
            check("pre_err", 32'(err), 32'(vecs[i].pre_err));
            c0 = done_cnt;
            if (vecs[i].exp_done) push_exp(vecs[i].data);
            send_byte(vecs[i].data, vecs[i].stop_v, vecs[i].stop_len, -1, 1'b0, 1'b1);
            check("vec_done", 32'(done_cnt - c0), 32'(vecs[i].exp_done));
            check("vec_err", 32'(err), 32'(vecs[i].exp_err));
            check("vec_data", 32'(data_out), 32'(vecs[i].exp_data));
        end

        // Short low glitch on idle line
        hold(2 * BIT);
        c0 = done_cnt;
        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        hold(10);
        check("glitch_busy_hi", 32'(busy), 32'(1));
        hold(100);
        check("glitch_busy_lo", 32'(busy), 32'(0));
        check("glitch_err", 32'(err), 32'(0));
        check("glitch_done", 32'(done_cnt - c0), 32'(0));

        // Enable dropped mid-frame, then a clean frame
        hold(BIT);
        c0 = done_cnt;
        send_byte(8'h81, 1'b1, 1, 4, 1'b0, 1'b0);
        hold(BIT);
        check("en_abort_done", 32'(done_cnt - c0), 32'(0));
        check("en_abort_err", 32'(err), 32'(0));
        en = 1'b1;
        hold(BIT);
        c0 = done_cnt;
        push_exp(8'h81);
        send_byte(8'h81, 1'b1, 1, -1, 1'b0, 1'b1);
        check("en_frame_done", 32'(done_cnt - c0), 32'(1));
        check("en_frame_data", 32'(data_out), 32'(8'h81));

        // Reset pulse mid-frame, then a clean frame
        hold(BIT);
        c0 = done_cnt;
        send_byte(8'hF0, 1'b1, 1, 4, 1'b1, 1'b0);
        hold(BIT);
        check("rst_abort_done", 32'(done_cnt - c0), 32'(0));
        c0 = done_cnt;
        push_exp(8'h7E);
        send_byte(8'h7E, 1'b1, 1, -1, 1'b0, 1'b1);
        check("rst_frame_done", 32'(done_cnt - c0), 32'(1));
        check("rst_frame_data", 32'(data_out), 32'(8'h7E));

        hold(2 * BIT);
        check("sb_drain", 32'(sb_q.size()), 32'(0));
        check("done_total", 32'(done_cnt), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish before 5ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Single-clock UART receive front end: oversampling baud tick generator, 8N1 receiver and one-cycle done-pulse generator in one block.
- Sits between the serial RX pin and the matrix-loading control FSM.
- The FSM consumes one byte per done pulse via data_out.

Parameters:
- CLOCK_RATE, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit period; must be an even value ≥ 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idles high.
- en  input  1  receiver enable.
- data_out  output  8  last correctly framed byte.
- done  output  1  one-clk pulse per correctly received byte.
- busy  output  1  high while a frame is in progress.
- err  output  1  framing-error flag.

Behaviour:
- Single clock domain. The baud rate is a clock-enable tick, not a derived clock.
- Tick divider: DIV = CLOCK_RATE / (BAUD_RATE*OVERSAMPLE), integer division, minimum 1 (default 651).
  - Counter runs 0..DIV-1 and asserts tick for one clk when the count equals DIV-1, then wraps to 0.
  - Counter free-runs; it is cleared only by rst.
- rx passes through a 2-flop synchronizer. Both flops reset to 1.
- State machine advances only on tick cycles, except for rst and en handling:
  - IDLE: when rx_sync is 0 on a tick, go to START with the sample counter at 0.
  - START: count OVERSAMPLE/2 ticks to reach mid-bit, then recheck rx_sync.
    - If 0: clear err, go to DATA with bit index 0.
    - If 1 (glitch): return to IDLE; no err, no done.
  - DATA: every OVERSAMPLE ticks sample rx_sync into shift register position bit index (LSB first). After the bit-7 sample, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_sync.
    - If 1: load data_out with the shift register, pulse done, go to IDLE.
    - If 0: set err, leave data_out unchanged, no done, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_sync is 1 on a tick, then go to IDLE. This stops a break condition from being re-read as a start bit.
- busy = 1 in START, DATA and STOP; 0 in IDLE and WAIT_IDLE.
- err is sticky: set on framing error, cleared only on the next valid start bit (mid-bit confirm) or rst.
- done is the edge-pulse output of the internal frame-complete flag. It is high exactly one clk per good frame and never two consecutive cycles.
- data_out changes only in the same cycle done rises and holds until the next good frame.
- en = 0:
  - Forces the FSM to IDLE on the next clk, aborting any frame in progress with no done and no err change.
  - Start bits are ignored while en is low.
  - The tick divider keeps running.
- Latency: done rises at most 9*OVERSAMPLE + OVERSAMPLE/2 ticks plus DIV+3 clk after the rx falling edge. Nominal is about 9.5 bit periods.
- Reset values: data_out = 8'h00, done = 0, busy = 0, err = 0, state IDLE, divider = 0.
- Reset mid-frame aborts with no done.
- Back-to-back frames (stop bit directly followed by start bit) must be received without loss.

Test Plan:
1. CLOCK_RATE=6_400_000, BAUD_RATE=100_000 (DIV=4, 64 clk/bit). Send 0xA5 8N1 → one done pulse, data_out=0xA5, err=0, busy high during the frame and low after.
2. Send 0x00, 0xFF, 0x3C back-to-back with no idle gap → exactly three done pulses with data_out 0x00, 0xFF, 0x3C in order.
3. Send 0x55 with the stop bit driven 0 for 2 bit periods → no done, err=1, data_out keeps its prior value. Then send 0x12 → err clears at its start bit, done pulses, data_out=0x12.
4. Drive a 20-clk low glitch on idle rx → no done, busy returns to 0, err=0.
5. Drop en at bit 4 of 0x81 → no done. Raise en and send 0x81 → done, data_out=0x81.
6. Assert rst for one clk mid-frame → all outputs return to reset values next cycle. A following 0x7E frame is received correctly.
